// File: rtl/stream_demux2_pkg.sv
// Shared definitions for the stream demux receive path: channel
// identifiers and default stream geometry, also used by the mux side.
package stream_demux2_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEMUX_WIDTH_DEF = 8;
    localparam int DEMUX_DEPTH_DEF = 2;

endpackage : stream_demux2_pkg

// File: rtl/stream_demux2_fifo.sv
// demux_fifo: small synchronous FIFO, one per demux channel.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// The head payload reads as zero while the FIFO is empty, which gives
// clean reset-state outputs without resetting the storage array.
module demux_fifo
    import stream_demux2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int DEPTH = DEMUX_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; a simultaneous push and pop
    // advances both pointers and leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : demux_fifo

// File: rtl/stream_demux2.sv
// stream_demux2: routes one valid/ready input stream to one of two
// output channels, each buffered by its own demux_fifo.
// Optional macro DEMUX_TDM_EN: ignore in_sel and alternate destinations
// ch0, ch1, ch0, ... using a toggle that flips on every accepted beat.
// in_ready depends only on registered occupancy and the destination, so
// there is no combinational path from outN_ready to in_ready.
module stream_demux2
    import stream_demux2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int DEPTH = DEMUX_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
);

    logic dest;
    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic accept;

`ifdef DEMUX_TDM_EN
    logic toggle_q, toggle_d;

    assign dest = toggle_q;

    // Toggle flips on each accepted beat so destinations strictly alternate.
    always_comb begin
        toggle_d = toggle_q;
        if (accept) begin
            toggle_d = ~toggle_q;
        end
    end

    // Toggle register, starting on channel 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= CH0;
        end else begin
            toggle_q <= toggle_d;
        end
    end
`else
    assign dest = in_sel;
`endif

    // No skipping: a full destination blocks input even if the other has room.
    assign in_ready = (dest == CH1) ? !full1 : !full0;
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (dest == CH0);
    assign push1    = accept && (dest == CH1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .pop       (out0_ready),
        .pop_data  (out0_data),
        .empty     (empty0)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .pop       (out1_ready),
        .pop_data  (out1_data),
        .empty     (empty1)
    );

endmodule : stream_demux2

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2 (WIDTH=8, DEPTH=2). Inputs change
// 1 time unit after a rising edge; outputs are checked 2 units later.
module tb_stream_demux2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_demux2 #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        rst        = 1'b1;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hEE);

        // Reset held three cycles with a beat presented
        repeat (3) tick();
        settle();
        chk("rst_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("rst_out1_valid", {7'd0, out1_valid}, 8'd0);
        chk("rst_out0_data",  out0_data, 8'h00);
        chk("rst_out1_data",  out1_data, 8'h00);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        settle();
        chk("rel_in_ready",   {7'd0, in_ready},   8'd1);
        chk("rel_out0_valid", {7'd0, out0_valid}, 8'd0);
        tick();
        chk("rel2_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("rel2_out1_valid", {7'd0, out1_valid}, 8'd0);

`ifndef DEMUX_TDM_EN
        // Routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA5);
        settle();
        chk("route_rdy0", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b1, 1'b1, 8'h3C);
        settle();
        chk("route_v0",   {7'd0, out0_valid}, 8'd1);
        chk("route_d0",   out0_data, 8'hA5);
        chk("route_v1a",  {7'd0, out1_valid}, 8'd0);
        chk("route_rdy1", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        settle();
        chk("route_v0b", {7'd0, out0_valid}, 8'd0);
        chk("route_v1",  {7'd0, out1_valid}, 8'd1);
        chk("route_d1",  out1_data, 8'h3C);
        tick();
        chk("route_v1c", {7'd0, out1_valid}, 8'd0);

        // Backpressure on channel 0
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h01);
        tick();
        drive(1'b1, 1'b0, 8'h02);
        tick();
        drive(1'b1, 1'b0, 8'h03);
        settle();
        chk("bp_full_rdy", {7'd0, in_ready}, 8'd0);
        drive(1'b1, 1'b1, 8'h77);
        settle();
        chk("bp_other_rdy", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        settle();
        chk("bp_d1",  out1_data, 8'h77);
        chk("bp_d0a", out0_data, 8'h01);
        out0_ready = 1'b1;
        tick();
        chk("bp_d0b", out0_data, 8'h02);
        chk("bp_v0b", {7'd0, out0_valid}, 8'd1);
        tick();
        chk("bp_v0c", {7'd0, out0_valid}, 8'd0);
        out1_ready = 1'b1;
        tick();
        chk("bp_v1c", {7'd0, out1_valid}, 8'd0);

        // Full with simultaneous pop
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h11);
        tick();
        drive(1'b1, 1'b0, 8'h22);
        tick();
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h33);
        settle();
        chk("fp_rdy_full", {7'd0, in_ready}, 8'd0);
        chk("fp_head",     out0_data, 8'h11);
        tick();
        settle();
        chk("fp_head2",   out0_data, 8'h22);
        chk("fp_rdy_next", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        settle();
        chk("fp_head3", out0_data, 8'h33);
        chk("fp_v0",    {7'd0, out0_valid}, 8'd1);
        tick();
        chk("fp_v0_end", {7'd0, out0_valid}, 8'd0);

        // Mid-stream reset
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h55);
        tick();
        drive(1'b1, 1'b0, 8'h66);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        settle();
        chk("mr_v0_pre", {7'd0, out0_valid}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("mr_v0",  {7'd0, out0_valid}, 8'd0);
        chk("mr_d0",  out0_data, 8'h00);
        chk("mr_rdy", {7'd0, in_ready}, 8'd1);
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h99);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        settle();
        chk("mr_new_d0", out0_data, 8'h99);
        tick();
        chk("mr_v0_end", {7'd0, out0_valid}, 8'd0);
`else
        // TDM alternation with in_sel held at 1
        drive(1'b1, 1'b1, 8'h10);
        settle();
        chk("tdm_rdy0", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b1, 1'b1, 8'h11);
        settle();
        chk("tdm_rdy1", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b1, 1'b1, 8'h12);
        settle();
        chk("tdm_rdy2", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b1, 1'b1, 8'h13);
        settle();
        chk("tdm_rdy3", {7'd0, in_ready}, 8'd1);
        tick();
        drive(1'b1, 1'b1, 8'h14);
        settle();
        chk("tdm_full_rdy", {7'd0, in_ready}, 8'd0);
        chk("tdm_d0a", out0_data, 8'h10);
        chk("tdm_d1a", out1_data, 8'h11);
        drive(1'b0, 1'b1, 8'h00);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        chk("tdm_d0b", out0_data, 8'h12);
        chk("tdm_d1b", out1_data, 8'h13);
        tick();
        chk("tdm_v0_end", {7'd0, out0_valid}, 8'd0);
        chk("tdm_v1_end", {7'd0, out1_valid}, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_stream_demux2
